// File: rtl/ni_pkg.sv
// Shared types and header-layout helpers for the NI transmit packetizer.
// The header is packed LSB first: dst_x, dst_y, src_x, src_y, len, seq; upper bits are zero.
package ni_pkg;

    localparam int NI_COORD_W = 2;
    localparam int NI_LEN_W   = 4;
    localparam int NI_SEQ_W   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } ni_state_e;

    // Field order matches the header flit: the first member is the most significant.
    typedef struct packed {
        logic [NI_SEQ_W-1:0]   seq;
        logic [NI_LEN_W-1:0]   len;
        logic [NI_COORD_W-1:0] src_y;
        logic [NI_COORD_W-1:0] src_x;
        logic [NI_COORD_W-1:0] dst_y;
        logic [NI_COORD_W-1:0] dst_x;
    } ni_hdr_t;

    function automatic int hdr_width(input int coord_w, input int len_w, input int seq_w);
        return 4 * coord_w + len_w + seq_w;
    endfunction

    function automatic bit hdr_fits(input int port_w, input int coord_w,
                                    input int len_w, input int seq_w);
        return hdr_width(coord_w, len_w, seq_w) <= port_w;
    endfunction

endpackage

// File: rtl/ni_out_stage.sv
// Single-register AXI-stream output stage: loads a flit, holds it while stalled,
// and drops valid when it drains with nothing new behind it.
module ni_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             tready,
    output logic             tvalid,
    output logic [WIDTH-1:0] tdata,
    output logic             tlast,
    output logic             out_free
);

    logic             tvalid_q, tvalid_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tlast_q, tlast_d;

    // Next-state for the output register: load wins, otherwise drain or hold.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = load_data;
            tlast_d  = load_last;
        end else if (tvalid_q & tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Output register with asynchronous reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign out_free = ~tvalid_q | tready;
    assign tvalid   = tvalid_q;
    assign tdata    = tdata_q;
    assign tlast    = tlast_q;

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: turns a descriptor plus N payload words into a header flit
// followed by N payload flits on an AXI-stream toward the router ingress.
module ni_packetizer
    import ni_pkg::*;
#(
    parameter int                 PORT_WIDTH = 32,
    parameter int                 COORD_W    = 2,
    parameter int                 LEN_W      = 4,
    parameter int                 SEQ_W      = 8,
    parameter logic [COORD_W-1:0] SRC_X      = '0,
    parameter logic [COORD_W-1:0] SRC_Y      = '0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [COORD_W-1:0]    desc_dst_x,
    input  logic [COORD_W-1:0]    desc_dst_y,
    input  logic [LEN_W-1:0]      desc_len,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [PORT_WIDTH-1:0] pld_data,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [PORT_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  busy
);

    localparam int HDR_W = hdr_width(COORD_W, LEN_W, SEQ_W);

    generate
        if (!hdr_fits(PORT_WIDTH, COORD_W, LEN_W, SEQ_W)) begin : g_hdr_chk
            $error("ni_packetizer: header fields do not fit in PORT_WIDTH");
        end
    endgenerate

    ni_state_e             state_q, state_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  out_free_s;
    logic                  desc_acc_s;
    logic                  pld_acc_s;
    logic                  load_s;
    logic                  load_last_s;
    logic [PORT_WIDTH-1:0] hdr_s;
    logic [PORT_WIDTH-1:0] load_data_s;

    // Handshakes stay low while reset is asserted, even though the FSM already sits in IDLE.
    assign desc_ready = (state_q == IDLE) & out_free_s & ~arst;
    assign pld_ready  = (state_q == BODY) & out_free_s & ~arst;
    assign desc_acc_s = desc_valid & desc_ready;
    assign pld_acc_s  = pld_valid & pld_ready;

    // Header assembly; the seq field carries the number of this message, before the increment.
    always_comb begin
        hdr_s            = '0;
        hdr_s[HDR_W-1:0] = {seq_q, desc_len, SRC_Y, SRC_X, desc_dst_y, desc_dst_x};
    end

    // Selects what the output register loads this cycle.
    always_comb begin
        load_s      = desc_acc_s | pld_acc_s;
        load_data_s = desc_acc_s ? hdr_s : pld_data;
        load_last_s = desc_acc_s ? (desc_len == LEN_W'(0)) : (rem_q == LEN_W'(1));
    end

    // FSM, remaining-word and sequence counters: next-state logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (desc_acc_s) begin
                    rem_d   = desc_len;
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = (desc_len == LEN_W'(0)) ? IDLE : BODY;
                end else begin
                    state_d = IDLE;
                end
            end
            BODY: begin
                if (pld_acc_s) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? IDLE : BODY;
                end else begin
                    state_d = BODY;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
        end
    end

    ni_out_stage #(
        .WIDTH(PORT_WIDTH)
    ) u_out (
        .clk      (clk),
        .arst     (arst),
        .load     (load_s),
        .load_data(load_data_s),
        .load_last(load_last_s),
        .tready   (m_tready),
        .tvalid   (m_tvalid),
        .tdata    (m_tdata),
        .tlast    (m_tlast),
        .out_free (out_free_s)
    );

    assign busy = (state_q == BODY) | m_tvalid;

endmodule
